rr_mux_arbiter: RTL and testbench

- Round-robin arbiter and sequencer for a shared N-to-1 multiplexer datapath.
- N requesters each present a valid/data/last stream. The block grants one requester at a time and drives the mux select from the grant. It forwards that requester's beats to a single downstream valid/ready channel.
- The grant is held for a whole burst, until the last beat or until the MAX_BEATS cap is reached.
- Sits between the multiple producers and the single consumer of a shared bus.

---
 rtl/rr_mux_pkg.sv | 10 +
 rtl/rr_pick.sv | 18 +
 rtl/rr_mux_arbiter.sv | 68 ++++++
 tb/tb_rr_mux_arbiter.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/rr_mux_pkg.sv
// rr_mux_pkg: shared types and width helpers for the round-robin mux arbiter
package rr_mux_pkg;
  typedef enum logic {IDLE, BUSY} state_t;
  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  function automatic int cnt_w(input int m);
    return $clog2(m) + 1;
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: rotate-priority picker, first set request at or above ptr with wrap
module rr_pick import rr_mux_pkg::*; #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [sel_w(N)-1:0]  ptr,
  output logic [sel_w(N)-1:0]  pick,
  output logic                 any_req
);
  localparam int SW = sel_w(N);
  assign any_req = |req;
  // scan farthest offset first so the nearest requester to ptr wins last
  always_comb begin
    pick = '0;
    for (int i = N - 1; i >= 0; i--)
      if (req[ptr + SW'(i)]) pick = ptr + SW'(i);
  end
endmodule

// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter: round-robin burst arbiter driving a shared N-to-1 mux
module rr_mux_arbiter import rr_mux_pkg::*; #(
  parameter int N         = 4,
  parameter int W         = 8,
  parameter int MAX_BEATS = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N-1:0]        req_valid,
  input  logic [N-1:0]        req_last,
  input  logic [N*W-1:0]      req_data,
  output logic [N-1:0]        req_ready,
  output logic                out_valid,
  output logic                out_last,
  output logic [W-1:0]        out_data,
  input  logic                out_ready,
  output logic [sel_w(N)-1:0] grant_idx,
  output logic                grant_active
);
  localparam int SW = sel_w(N);
  localparam int CW = cnt_w(MAX_BEATS);
  state_t        state;
  logic [SW-1:0] ptr;
  logic [SW-1:0] pick;
  logic          any_req;
  logic [CW-1:0] cnt;
  logic          busy;
  logic          at_cap;
  rr_pick #(.N(N)) u_pick (
    .req     (req_valid),
    .ptr     (ptr),
    .pick    (pick),
    .any_req (any_req)
  );
  assign busy         = state == BUSY;
  assign grant_active = busy;
  assign at_cap       = cnt == CW'(MAX_BEATS - 1);
  // the data path is a pure mux on the registered owner; nothing is stored
  always_comb begin
    out_valid = busy && req_valid[grant_idx];
    out_last  = busy && (req_last[grant_idx] || at_cap);
    out_data  = busy ? req_data[grant_idx*W +: W] : '0;
    req_ready = (busy && out_ready) ? N'(1) << grant_idx : '0;
  end
  // grant on the IDLE->BUSY edge, release and rotate on the final accepted beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      grant_idx <= '0;
      ptr       <= '0;
      cnt       <= '0;
    end else if (!busy) begin
      if (any_req) begin
        state     <= BUSY;
        grant_idx <= pick;
        cnt       <= '0;
      end
    end else if (out_valid && out_ready) begin
      if (out_last) begin
        state <= IDLE;
        ptr   <= grant_idx + 1'b1;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_rr_mux_arbiter.sv
// tb_rr_mux_arbiter: table-driven per-cycle check of the round-robin mux arbiter
module tb_rr_mux_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [3:0]  req_last = '0;
  logic [31:0] req_data = '0;
  logic        out_ready = 1'b0;
  logic [3:0]  req_ready;
  logic        out_valid;
  logic        out_last;
  logic [7:0]  out_data;
  logic [1:0]  grant_idx;
  logic        grant_active;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  rr_mux_arbiter #(.N(4), .W(8), .MAX_BEATS(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_last     (req_last),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .out_valid    (out_valid),
    .out_last     (out_last),
    .out_data     (out_data),
    .out_ready    (out_ready),
    .grant_idx    (grant_idx),
    .grant_active (grant_active)
  );

  typedef struct {
    logic        rn;
    logic [3:0]  v;
    logic [3:0]  l;
    logic [31:0] d;
    logic        rdy;
    logic [16:0] e;
  } vec_t;
  vec_t vq[$];

  function automatic logic [16:0] ex(input logic a, input logic [1:0] g, input logic [3:0] rr,
                                     input logic ov, input logic ol, input logic [7:0] od);
    return {a, g, rr, ov, ol, od};
  endfunction

  function automatic logic [16:0] z(input logic [1:0] g);
    return ex(1'b0, g, 4'b0, 1'b0, 1'b0, 8'h00);
  endfunction

  task automatic add(input logic rn, input logic [3:0] v, input logic [3:0] l,
                     input logic [31:0] d, input logic rdy, input logic [16:0] e);
    vec_t t;
    t.rn = rn; t.v = v; t.l = l; t.d = d; t.rdy = rdy; t.e = e;
    vq.push_back(t);
  endtask

  function automatic logic [16:0] got();
    return {grant_active, grant_idx, req_ready, out_valid, out_last, out_data};
  endfunction

  task automatic check(input string nm, input logic [16:0] e);
    total++;
    if (got() !== e) begin
      bad++;
      $display("FAIL %s got act/g/rdy/v/l/d=%h want=%h", nm, got(), e);
    end
  endtask

  initial begin
    int n;
    // single requester, 3-beat burst
    add(1'b1, 4'b0010, 4'b0000, 32'h0000_1100, 1'b1, z(2'd0));
    add(1'b1, 4'b0010, 4'b0000, 32'h0000_1100, 1'b1, ex(1'b1, 2'd1, 4'b0010, 1'b1, 1'b0, 8'h11));
    add(1'b1, 4'b0010, 4'b0000, 32'h0000_2200, 1'b1, ex(1'b1, 2'd1, 4'b0010, 1'b1, 1'b0, 8'h22));
    add(1'b1, 4'b0010, 4'b0010, 32'h0000_3300, 1'b1, ex(1'b1, 2'd1, 4'b0010, 1'b1, 1'b1, 8'h33));
    add(1'b1, 4'b0000, 4'b0000, 32'h0, 1'b1, z(2'd1));
    // reset pointer, then all four requesting single-beat bursts
    add(1'b0, 4'hF, 4'hF, 32'hD3D2D1D0, 1'b1, z(2'd0));
    for (int k = 0; k < 6; k++) begin
      add(1'b1, 4'hF, 4'hF, 32'hD3D2D1D0, 1'b1, z(k == 0 ? 2'd0 : 2'((k - 1) % 4)));
      add(1'b1, 4'hF, 4'hF, 32'hD3D2D1D0, 1'b1,
          ex(1'b1, 2'(k % 4), 4'(1 << (k % 4)), 1'b1, 1'b1, 8'(8'hD0 + k % 4)));
    end
    add(1'b1, 4'b0000, 4'b0000, 32'h0, 1'b1, z(2'd1));
    // backpressure on requester 2
    add(1'b1, 4'b0100, 4'b0000, 32'h00A1_0000, 1'b0, z(2'd1));
    add(1'b1, 4'b0100, 4'b0000, 32'h00A1_0000, 1'b0, ex(1'b1, 2'd2, 4'b0000, 1'b1, 1'b0, 8'hA1));
    add(1'b1, 4'b0100, 4'b0000, 32'h00A1_0000, 1'b1, ex(1'b1, 2'd2, 4'b0100, 1'b1, 1'b0, 8'hA1));
    add(1'b1, 4'b0100, 4'b0100, 32'h00A2_0000, 1'b0, ex(1'b1, 2'd2, 4'b0000, 1'b1, 1'b1, 8'hA2));
    add(1'b1, 4'b0100, 4'b0100, 32'h00A2_0000, 1'b1, ex(1'b1, 2'd2, 4'b0100, 1'b1, 1'b1, 8'hA2));
    add(1'b1, 4'b0000, 4'b0000, 32'h0, 1'b1, z(2'd2));
    // forced release after 4 beats, then regrant for beats 5-6
    add(1'b1, 4'b0001, 4'b0000, 32'h0000_00B1, 1'b1, z(2'd2));
    for (int k = 1; k <= 4; k++)
      add(1'b1, 4'b0001, 4'b0000, 32'(8'hB0 + k), 1'b1,
          ex(1'b1, 2'd0, 4'b0001, 1'b1, k == 4, 8'(8'hB0 + k)));
    add(1'b1, 4'b0001, 4'b0000, 32'h0000_00B5, 1'b1, z(2'd0));
    add(1'b1, 4'b0001, 4'b0000, 32'h0000_00B5, 1'b1, ex(1'b1, 2'd0, 4'b0001, 1'b1, 1'b0, 8'hB5));
    add(1'b1, 4'b0001, 4'b0001, 32'h0000_00B6, 1'b1, ex(1'b1, 2'd0, 4'b0001, 1'b1, 1'b1, 8'hB6));
    add(1'b1, 4'b0000, 4'b0000, 32'h0, 1'b1, z(2'd0));
    // valid gap mid-burst on requester 3, then reset mid-burst
    add(1'b1, 4'b1000, 4'b0000, 32'hC100_0000, 1'b1, z(2'd0));
    add(1'b1, 4'b1000, 4'b0000, 32'hC100_0000, 1'b1, ex(1'b1, 2'd3, 4'b1000, 1'b1, 1'b0, 8'hC1));
    for (int k = 0; k < 3; k++)
      add(1'b1, 4'b0000, 4'b0000, 32'hC200_0000, 1'b1, ex(1'b1, 2'd3, 4'b1000, 1'b0, 1'b0, 8'hC2));
    add(1'b1, 4'b1000, 4'b0000, 32'hC200_0000, 1'b1, ex(1'b1, 2'd3, 4'b1000, 1'b1, 1'b0, 8'hC2));
    add(1'b0, 4'b1000, 4'b0000, 32'hC300_0000, 1'b1, z(2'd0));
    add(1'b1, 4'b1001, 4'b1001, 32'hC300_00E0, 1'b1, z(2'd0));
    add(1'b1, 4'b1001, 4'b1001, 32'hC300_00E0, 1'b1, ex(1'b1, 2'd0, 4'b0001, 1'b1, 1'b1, 8'hE0));
    // grant to 2, new requests 3 and 0 arriving on its release cycle
    add(1'b1, 4'b0100, 4'b0100, 32'h00F2_0000, 1'b1, z(2'd0));
    add(1'b1, 4'b1101, 4'b1101, 32'hF3F2_00F0, 1'b1, ex(1'b1, 2'd2, 4'b0100, 1'b1, 1'b1, 8'hF2));
    add(1'b1, 4'b1001, 4'b1001, 32'hF300_00F0, 1'b1, z(2'd2));
    add(1'b1, 4'b1001, 4'b1001, 32'hF300_00F0, 1'b1, ex(1'b1, 2'd3, 4'b1000, 1'b1, 1'b1, 8'hF3));
    add(1'b1, 4'b1001, 4'b1001, 32'hF300_00F0, 1'b1, z(2'd3));
    add(1'b1, 4'b1001, 4'b1001, 32'hF300_00F0, 1'b1, ex(1'b1, 2'd0, 4'b0001, 1'b1, 1'b1, 8'hF0));
    add(1'b1, 4'b0000, 4'b0000, 32'h0, 1'b1, z(2'd0));

    @(negedge clk);
    #1 check("reset", z(2'd0));
    foreach (vq[i]) begin
      @(negedge clk);
      rst_n = vq[i].rn;
      req_valid = vq[i].v;
      req_last = vq[i].l;
      req_data = vq[i].d;
      out_ready = vq[i].rdy;
      #1 check($sformatf("vec%0d", i), vq[i].e);
    end

    // async reset between clock edges while a stalled burst is held
    @(negedge clk);
    req_valid = 4'b0100;
    req_last = 4'b0000;
    req_data = 32'h0077_0000;
    out_ready = 1'b0;
    n = 0;
    while (!grant_active && n < 4) begin
      @(negedge clk);
      n++;
    end
    if (!grant_active) begin
      total++;
      bad++;
      $display("FAIL grant_wait got active=0 want active=1 within 4 cycles");
    end
    #1 check("busy_hold", ex(1'b1, 2'd2, 4'b0000, 1'b1, 1'b0, 8'h77));
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_rst", z(2'd0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
